// File: rtl/writeback_arbiter.sv
// Merges an unstallable ALU result stream and a buffered load-result stream onto
// one registered register-file write port, with pending-register tracking.
module writeback_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_NUM_WIDTH = 5,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            aluValid,
    input  logic [REG_NUM_WIDTH-1:0]        aluNum,
    input  logic [DATA_WIDTH-1:0]           aluData,
    input  logic                            ldValid,
    output logic                            ldReady,
    input  logic [REG_NUM_WIDTH-1:0]        ldNum,
    input  logic [DATA_WIDTH-1:0]           ldData,
    output logic                            wrEnable,
    output logic [REG_NUM_WIDTH-1:0]        wrNum,
    output logic [DATA_WIDTH-1:0]           wrData,
    output logic [(1<<REG_NUM_WIDTH)-1:0]   pending,
    output logic                            aluStall,
    output logic                            err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

    logic [REG_NUM_WIDTH-1:0] r_fifo_num  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W:0]           r_count;

    logic                     r_wr_en;
    logic                     r_wr_is_ld;
    logic [REG_NUM_WIDTH-1:0] r_wr_num;
    logic [DATA_WIDTH-1:0]    r_wr_data;
    logic [1:0]               r_starve;
    logic                     r_err;

    logic                     w_empty;
    logic                     w_full;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_sel_valid;
    logic                     w_sel_is_ld;
    logic [REG_NUM_WIDTH-1:0] w_sel_num;
    logic [DATA_WIDTH-1:0]    w_sel_data;
    logic [(1<<REG_NUM_WIDTH)-1:0] w_pending;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);

    // Gated with rst_n so the port reads not-ready while reset is held.
    assign ldReady = rst_n & ~w_full;
    assign w_push  = ldValid & ldReady & (ldNum != '0);
    assign w_pop   = ~aluValid & ~w_empty;

    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_is_ld = 1'b0;
        w_sel_num   = '0;
        w_sel_data  = '0;
        if (aluValid) begin
            w_sel_valid = 1'b1;
            w_sel_num   = aluNum;
            w_sel_data  = aluData;
        end else if (w_pop) begin
            w_sel_valid = 1'b1;
            w_sel_is_ld = 1'b1;
            w_sel_num   = r_fifo_num[r_rd_ptr];
            w_sel_data  = r_fifo_data[r_rd_ptr];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the entry storage has no reset; r_count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_num[r_wr_ptr]  <= ldNum;
            r_fifo_data[r_wr_ptr] <= ldData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en    <= 1'b0;
            r_wr_is_ld <= 1'b0;
            r_wr_num   <= '0;
            r_wr_data  <= '0;
        end else begin
            r_wr_en    <= w_sel_valid & (w_sel_num != '0);
            r_wr_is_ld <= w_sel_is_ld;
            if (w_sel_valid) begin
                r_wr_num  <= w_sel_num;
                r_wr_data <= w_sel_data;
            end
        end
    end

    // Counts consecutive cycles in which the ALU blocks a non-empty load queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= 2'd0;
            r_err    <= 1'b0;
        end else begin
            if (w_pop || w_empty)
                r_starve <= 2'd0;
            else if (aluValid && r_starve != 2'd3)
                r_starve <= r_starve + 2'd1;
            if (aluValid && aluStall)
                r_err <= 1'b1;
        end
    end

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if ((PTR_W+1)'(i) < r_count)
                w_pending[r_fifo_num[r_rd_ptr + PTR_W'(i)]] = 1'b1;
        end
        if (r_wr_en && r_wr_is_ld)
            w_pending[r_wr_num] = 1'b1;
        w_pending[0] = 1'b0;
    end

    assign pending  = w_pending;
    assign wrEnable = r_wr_en;
    assign wrNum    = r_wr_num;
    assign wrData   = r_wr_data;
    assign aluStall = (r_starve == 2'd3);
    assign err      = r_err;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_writeback_arbiter;

    localparam int DW    = 32;
    localparam int RW    = 5;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           aluValid = 1'b0;
    logic [RW-1:0]  aluNum = '0;
    logic [DW-1:0]  aluData = '0;
    logic           ldValid = 1'b0;
    logic           ldReady;
    logic [RW-1:0]  ldNum = '0;
    logic [DW-1:0]  ldData = '0;
    logic           wrEnable;
    logic [RW-1:0]  wrNum;
    logic [DW-1:0]  wrData;
    logic [31:0]    pending;
    logic           aluStall;
    logic           err;

    int n_chk = 0;
    int n_err = 0;

    writeback_arbiter #(.DATA_WIDTH(DW), .REG_NUM_WIDTH(RW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .aluValid(aluValid), .aluNum(aluNum), .aluData(aluData),
        .ldValid(ldValid), .ldReady(ldReady), .ldNum(ldNum), .ldData(ldData),
        .wrEnable(wrEnable), .wrNum(wrNum), .wrData(wrData),
        .pending(pending), .aluStall(aluStall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queued loads plus the visible write-port contents.
    typedef struct {
        logic [RW-1:0] num;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          m_q[$];
    logic          m_wr_en = 1'b0;
    logic          m_wr_is_ld = 1'b0;
    logic [RW-1:0] m_wr_num = '0;
    logic [DW-1:0] m_wr_data = '0;
    int            m_cnt = 0;
    logic          m_err = 1'b0;
    int            m_sz;
    logic          m_popped;
    ent_t          m_e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_wr_en = 1'b0; m_wr_is_ld = 1'b0; m_wr_num = '0; m_wr_data = '0;
            m_cnt = 0; m_err = 1'b0;
        end else begin
            m_sz = m_q.size();
            m_popped = 1'b0;
            if (aluValid && m_cnt == 3) m_err = 1'b1;
            if (aluValid) begin
                m_wr_en = (aluNum != 0); m_wr_is_ld = 1'b0;
                m_wr_num = aluNum; m_wr_data = aluData;
            end else if (m_sz > 0) begin
                m_e = m_q.pop_front();
                m_popped = 1'b1;
                m_wr_en = (m_e.num != 0); m_wr_is_ld = 1'b1;
                m_wr_num = m_e.num; m_wr_data = m_e.data;
            end else begin
                m_wr_en = 1'b0; m_wr_is_ld = 1'b0;
            end
            if (ldValid && m_sz < DEPTH && ldNum != 0) begin
                m_e.num = ldNum; m_e.data = ldData;
                m_q.push_back(m_e);
            end
            if (m_popped || m_sz == 0) m_cnt = 0;
            else if (aluValid) m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
        end
    end

    logic [31:0] exp_pend;
    always @(negedge clk) begin
        exp_pend = '0;
        foreach (m_q[i]) exp_pend[m_q[i].num] = 1'b1;
        if (m_wr_en && m_wr_is_ld) exp_pend[m_wr_num] = 1'b1;
        exp_pend[0] = 1'b0;
        check("cmp_ldReady", ldReady, rst_n && m_q.size() < DEPTH);
        check("cmp_wrEnable", wrEnable, m_wr_en);
        check("cmp_wrNum", wrNum, m_wr_num);
        check("cmp_wrData", wrData, m_wr_data);
        check("cmp_pending", pending, exp_pend);
        check("cmp_aluStall", aluStall, m_cnt == 3);
        check("cmp_err", err, m_err);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        aluValid = 1'b0; aluNum = '0; aluData = '0;
        ldValid = 1'b0; ldNum = '0; ldData = '0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        check("rst_ldReady", ldReady, 0);
        check("rst_wrEnable", wrEnable, 0);
        check("rst_wrNum", wrNum, 0);
        check("rst_wrData", wrData, 0);
        check("rst_pending", pending, 0);
        check("rst_aluStall", aluStall, 0);
        check("rst_err", err, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        #1 check("rel_ldReady", ldReady, 1);
        cyc();

        // ALU only
        aluValid = 1'b1; aluNum = 5'd3; aluData = 32'h11;
        cyc();
        aluValid = 1'b0;
        check("alu_wrEnable", wrEnable, 1);
        check("alu_wrNum", wrNum, 3);
        check("alu_wrData", wrData, 32'h11);
        check("alu_pending", pending, 0);
        cyc();

        // Load path
        ldValid = 1'b1; ldNum = 5'd7; ldData = 32'hA5;
        cyc();
        ldValid = 1'b0;
        check("ld_pend_t1", pending, 32'h80);
        check("ld_wrEn_t1", wrEnable, 0);
        cyc();
        check("ld_wrEn_t2", wrEnable, 1);
        check("ld_wrNum_t2", wrNum, 7);
        check("ld_wrData_t2", wrData, 32'hA5);
        check("ld_pend_t2", pending, 32'h80);
        cyc();
        check("ld_pend_t3", pending, 0);
        check("ld_wrEn_t3", wrEnable, 0);

        // Full and starvation
        for (int i = 1; i <= 4; i++) begin
            check("full_ldReady_open", ldReady, 1);
            check("full_stall_low", aluStall, 0);
            aluValid = 1'b1; aluNum = 5'd20; aluData = 32'h200 + i;
            ldValid = 1'b1; ldNum = 5'(i); ldData = 32'h100 + i;
            cyc();
        end
        ldValid = 1'b0;
        check("full_ldReady", ldReady, 0);
        check("full_aluStall", aluStall, 1);
        check("full_pending", pending, 32'h1E);
        check("model_qlen_full", m_q.size(), 4);
        aluValid = 1'b0;
        cyc();
        for (int j = 1; j <= 4; j++) begin
            check("drain_wrEnable", wrEnable, 1);
            check("drain_wrNum", wrNum, j);
            check("drain_wrData", wrData, 32'h100 + j);
            cyc();
        end
        check("drain_done", wrEnable, 0);
        check("drain_err", err, 0);

        // Violation
        aluValid = 1'b1; aluNum = 5'd9; aluData = 32'h1;
        ldValid = 1'b1; ldNum = 5'd5; ldData = 32'h55;
        cyc();
        ldValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            aluData = 32'h10 + k;
            cyc();
        end
        check("viol_stall", aluStall, 1);
        check("model_cnt_sat", m_cnt, 3);
        aluData = 32'hBEEF;
        cyc();
        aluValid = 1'b0;
        check("viol_wrEnable", wrEnable, 1);
        check("viol_wrNum", wrNum, 9);
        check("viol_wrData", wrData, 32'hBEEF);
        check("viol_err", err, 1);
        cyc();
        check("viol_ld_wrNum", wrNum, 5);
        check("viol_ld_wrData", wrData, 32'h55);
        cyc();
        cyc();
        check("viol_err_sticky", err, 1);
        check("viol_stall_clear", aluStall, 0);

        // Register zero
        aluValid = 1'b1; aluNum = 5'd0; aluData = 32'h77;
        cyc();
        aluValid = 1'b0;
        check("r0_alu_wrEnable", wrEnable, 0);
        check("r0_alu_pending", pending, 0);
        ldValid = 1'b1; ldNum = 5'd0; ldData = 32'h99;
        cyc();
        ldValid = 1'b0;
        check("r0_ld_pending", pending, 0);
        check("model_r0_nopush", m_q.size(), 0);
        cyc();
        check("r0_ld_wrEnable", wrEnable, 0);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) begin
            aluValid = 1'b1; aluNum = 5'd12; aluData = 32'h300 + i;
            ldValid = 1'b1; ldNum = 5'(20 + i); ldData = 32'h400 + i;
            cyc();
        end
        ldValid = 1'b0;
        check("mid_pending_q", pending, 32'h0070_0000);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wrEnable", wrEnable, 0);
        check("mid_rst_pending", pending, 0);
        check("mid_rst_ldReady", ldReady, 0);
        check("mid_rst_err", err, 0);
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        #1 check("mid_rel_ldReady", ldReady, 1);
        for (int i = 0; i < 6; i++) begin
            cyc();
            check("mid_no_stale", wrEnable, 0);
        end

        // Randomized traffic, one mid-run reset
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) begin
                #2 rst_n = 1'b0;
                idle_inputs();
                repeat (2) @(posedge clk);
                @(negedge clk); #2 rst_n = 1'b1;
                cyc();
            end
            aluValid = ($urandom_range(0, 3) != 0) && !(aluStall && $urandom_range(0, 7) != 0);
            aluNum   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            aluData  = $urandom;
            ldValid  = ($urandom_range(0, 1) == 1);
            ldNum    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            ldData   = $urandom;
            cyc();
        end
        idle_inputs();
        repeat (8) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 32, data width of a result.
- REG_NUM_WIDTH, 5, register number width (32 registers).
- FIFO_DEPTH, 4, number of load-result buffer entries (a power of 2, at least 2).
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- aluValid  in  1  ALU result present this cycle; it cannot be back-pressured.
- aluNum  in  REG_NUM_WIDTH  ALU destination register.
- aluData  in  DATA_WIDTH  ALU result.
- ldValid  in  1  load result offered.
- ldReady  out  1  load result accepted this cycle when ldValid is also high.
- ldNum  in  REG_NUM_WIDTH  load destination register.
- ldData  in  DATA_WIDTH  load result.
- wrEnable  out  1  register-file write strobe (registered).
- wrNum  out  REG_NUM_WIDTH  register-file write index (registered).
- wrData  out  DATA_WIDTH  register-file write data (registered).
- pending  out  2^REG_NUM_WIDTH  bit r high while a load result for register r is not yet written.
- aluStall  out  1  request that upstream withhold aluValid next cycle.
- err  out  1  sticky protocol-violation flag.

Function
REQ-003 The block SHALL merge ALU and load results onto the single register-file write port, with at most one write per cycle.
REQ-004 A load SHALL be accepted on any cycle where ldValid and ldReady are both high; ldReady SHALL equal "FIFO not full" and SHALL NOT depend on ldValid or on a same-cycle pop.
REQ-005 An accepted load with ldNum != 0 SHALL be pushed to the FIFO tail; an accepted load with ldNum == 0 SHALL be discarded and not pushed.
REQ-006 Per-cycle selection SHALL be: if aluValid, the ALU result; else if the FIFO is non-empty, pop the FIFO head; else nothing.
REQ-007 The selected result SHALL be registered into wrEnable/wrNum/wrData at the next edge. wrEnable SHALL be 0 when nothing is selected or when the selected number is 0. wrNum/wrData SHALL hold their previous values when nothing is selected.
REQ-008 Latency SHALL be:
- ALU result present in cycle t appears on the write port in cycle t+1.
- Load accepted in cycle t into an empty FIFO, with aluValid low in cycle t+1, appears on the write port in cycle t+2.
REQ-009 The FIFO SHALL preserve load order. A push and a pop in the same cycle SHALL both take effect, leaving the occupancy unchanged. Pointers SHALL wrap modulo FIFO_DEPTH.
REQ-010 pending[r] SHALL be combinationally 1 iff either:
- a FIFO entry holds register r, or
- the write-port register holds a load result with wrEnable high and wrNum == r.
pending[0] SHALL always be 0.
REQ-011 A starvation counter (0..3) SHALL behave as follows:
- increment, saturating at 3, on each cycle where aluValid is high and the FIFO is non-empty;
- clear on any cycle where the FIFO pops or the FIFO is empty.
aluStall SHALL equal (counter == 3).
REQ-012 If aluValid is high while aluStall is high, the ALU result SHALL still win arbitration, and err SHALL set and remain set until reset.
REQ-013 Ordering between an ALU write and an older queued load to the same register is the upstream's responsibility, enforced through pending. The block SHALL NOT reorder or drop results to resolve it.

Reset
REQ-014 While rst_n is low, the block SHALL hold:
- FIFO empty, both pointers 0;
- wrEnable 0, wrNum 0, wrData 0;
- pending all 0;
- starvation counter 0, aluStall 0, err 0;
- ldReady 0.
REQ-015 Assertion of rst_n mid-operation SHALL immediately discard all queued loads with no further writes. ldReady SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- ALU only: aluValid=1, aluNum=3, aluData=0x11 in cycle t -> wrEnable=1, wrNum=3, wrData=0x11 in cycle t+1; pending stays 0.
- Load path: ldValid=1, ldNum=7, ldData=0xA5 in cycle t, aluValid=0 -> pending[7]=1 from t+1; write of 7/0xA5 in cycle t+2; pending[7]=0 in cycle t+3.
- Full and starvation: aluValid=1 continuously while 4 loads (registers 1..4) are accepted -> ldReady=0 once 4 entries are queued; aluStall=1 after 3 contended cycles; drop aluValid -> registers 1,2,3,4 written in order on consecutive cycles.
- Violation: keep aluValid=1 while aluStall=1 -> ALU still written, err=1 and remains 1 after ALU traffic stops.
- Register zero: aluNum=0 or accepted ldNum=0 -> wrEnable stays 0; no FIFO push; pending unchanged.
- Reset mid-operation: 3 loads queued, pull rst_n low asynchronously -> same cycle wrEnable=0, pending=0, ldReady=0; after release, no stale writes occur.
